// File: rtl/if_fetch_stage_pkg.sv
// cpu_pkg: shared fetch-stage constants, stall/flush bit positions and the
// fetch FSM state type.
package cpu_pkg;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;  // addi x0, x0, 0
    localparam int          SF_STALL_BIT = 0;
    localparam int          SF_FLUSH_BIT = 1;
    localparam int          PC_STEP      = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } if_state_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: Wishbone classic read-only instruction bus between the
// fetch stage (master) and instruction memory (slave).
interface if_fetch_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                    wb_cyc_o;
    logic                    wb_stb_o;
    logic                    wb_we_o;
    logic [DATA_WIDTH/8-1:0] wb_sel_o;
    logic [ADDR_WIDTH-1:0]   wb_adr_o;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic                    wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the PC, fetches one instruction per bus cycle over
// Wishbone and hands instruction + PC to the IF/ID register.
// Optional bus timeout: define IF_BUS_TIMEOUT_EN to add the timeout counter
// and the fetch_fault_o port.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
`ifdef IF_BUS_TIMEOUT_EN
    ,
    parameter int                    TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            pc_stall_and_flush,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    if_fetch_stage_if.master      wb,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  inst_valid_o,
`ifdef IF_BUS_TIMEOUT_EN
    output logic                  fetch_fault_o,
`endif
    output logic                  im_busy_o
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);
    localparam logic [DATA_WIDTH-1:0] NOP  = DATA_WIDTH'(NOP_INST);

    if_state_t             state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_buf;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] inst_buf;
    logic [DATA_WIDTH-1:0] inst_q;
    logic                  cyc_q;
    logic                  valid_q;
    logic                  redirect_pend;
    logic                  stall;
    logic                  flush;
    logic                  timeout;
    logic [ADDR_WIDTH-1:0] redirect_next;

    assign stall = pc_stall_and_flush[SF_STALL_BIT];
    assign flush = pc_stall_and_flush[SF_FLUSH_BIT];

    // A redirect arriving in the same cycle as the drain ack is the latest one.
    assign redirect_next = branch_taken ? branch_target : redirect_pc;

    assign im_busy_o   = (state == FETCH) || (state == DRAIN);
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_we_o  = 1'b0;
    assign wb.wb_sel_o = '1;
    assign wb.wb_adr_o = adr_q;

    // A flush in the delivery cycle kills the instruction on its way to IF/ID.
    assign inst_valid_o = valid_q & ~flush;
    assign inst_o       = (valid_q & flush) ? NOP : inst_q;
    assign pc_o         = pc_q;

`ifdef IF_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt;
    logic          fault_q;

    assign timeout       = im_busy_o && !wb.wb_ack_i && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign fetch_fault_o = fault_q;

    // Count unacknowledged bus cycles; restart on ack, timeout or bus idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= timeout;
            if (!im_busy_o || wb.wb_ack_i || timeout) tmo_cnt <= '0;
            else                                      tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Fetch FSM: bus handshake, PC update, redirect tracking, delivery register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pc            <= PC_ADDR;
            pc_buf        <= PC_ADDR;
            redirect_pc   <= PC_ADDR;
            redirect_pend <= 1'b0;
            cyc_q         <= 1'b0;
            adr_q         <= PC_ADDR;
            inst_buf      <= NOP;
            inst_q        <= NOP;
            pc_q          <= PC_ADDR;
            valid_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking default makes inst_valid_o a one-cycle pulse; later
            // assignments in the same cycle override it without ordering hazards.
            valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (branch_taken) begin
                        pc    <= branch_target;
                        adr_q <= branch_target;
                    end else begin
                        adr_q <= pc;
                    end
                    cyc_q <= 1'b1;
                    state <= FETCH;
                end
                FETCH: begin
                    if (timeout) begin
                        cyc_q <= 1'b0;
                        state <= IDLE;
                        if (branch_taken) begin
                            pc <= branch_target;
                        end else begin
                            inst_q  <= NOP;
                            pc_q    <= pc;
                            valid_q <= 1'b1;
                            pc      <= pc + STEP;
                        end
                    end else if (wb.wb_ack_i && !redirect_pend) begin
                        cyc_q <= 1'b0;
                        if (branch_taken) begin
                            // Bus cycle already finished: drop the word, refetch at target.
                            pc    <= branch_target;
                            state <= IDLE;
                        end else begin
                            inst_buf <= wb.wb_dat_i;
                            pc_buf   <= pc;
                            if (stall) begin
                                state <= HOLD;
                            end else begin
                                inst_q  <= wb.wb_dat_i;
                                pc_q    <= pc;
                                valid_q <= 1'b1;
                                pc      <= pc + STEP;
                                state   <= IDLE;
                            end
                        end
                    end else if (branch_taken) begin
                        redirect_pc   <= branch_target;
                        redirect_pend <= 1'b1;
                        state         <= DRAIN;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        pc    <= branch_target;
                        state <= IDLE;
                    end else if (flush) begin
                        state <= IDLE;
                    end else if (!stall) begin
                        inst_q  <= inst_buf;
                        pc_q    <= pc_buf;
                        valid_q <= 1'b1;
                        pc      <= pc + STEP;
                        adr_q   <= pc + STEP;
                        cyc_q   <= 1'b1;
                        state   <= FETCH;
                    end
                end
                DRAIN: begin
                    if (branch_taken) redirect_pc <= branch_target;
                    if (wb.wb_ack_i || timeout) begin
                        // Ack: issue the redirected fetch at once; timeout: idle first.
                        pc            <= redirect_next;
                        adr_q         <= redirect_next;
                        redirect_pend <= 1'b0;
                        cyc_q         <= wb.wb_ack_i;
                        state         <= wb.wb_ack_i ? FETCH : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: self-checking bench for if_fetch_stage. A behavioural
// Wishbone slave with programmable wait states serves a synthetic memory;
// expected PCs, bus addresses and instruction words are computed from the
// fetch rules with plain arithmetic. A second instance starts at 32'hFFFF_FFFC.
module tb_if_fetch_stage;

    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam logic [31:0] PC_A   = 32'h8000_0000;
    localparam logic [31:0] PC_W   = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] FIXED  = 32'h0010_0093;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    sf;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic [DW-1:0] inst_o, inst2;
    logic [AW-1:0] pc_o, pc2;
    logic          inst_valid_o, valid2;
    logic          im_busy_o, busy2;
`ifdef IF_BUS_TIMEOUT_EN
    logic          fault, fault2;
`endif

    int total = 0;
    int bad   = 0;

    int   wait_n;
    logic fixed_en;
    int   slv_cnt;

    always #5 clk = ~clk;

    if_fetch_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb  ();
    if_fetch_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb2 ();

    if_fetch_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PC_ADDR(PC_A)) dut (
        .clk                (clk),
        .reset              (reset),
        .pc_stall_and_flush (sf),
        .branch_taken       (branch_taken),
        .branch_target      (branch_target),
        .wb                 (wb),
        .inst_o             (inst_o),
        .pc_o               (pc_o),
        .inst_valid_o       (inst_valid_o),
`ifdef IF_BUS_TIMEOUT_EN
        .fetch_fault_o      (fault),
`endif
        .im_busy_o          (im_busy_o)
    );

    if_fetch_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PC_ADDR(PC_W)) dut_wrap (
        .clk                (clk),
        .reset              (reset),
        .pc_stall_and_flush (2'b00),
        .branch_taken       (1'b0),
        .branch_target      (32'h0),
        .wb                 (wb2),
        .inst_o             (inst2),
        .pc_o               (pc2),
        .inst_valid_o       (valid2),
`ifdef IF_BUS_TIMEOUT_EN
        .fetch_fault_o      (fault2),
`endif
        .im_busy_o          (busy2)
    );

    // Synthetic instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // Slave for the main instance: ack after wait_n stalled strobe cycles.
    assign wb.wb_ack_i = wb.wb_cyc_o && wb.wb_stb_o && (slv_cnt >= wait_n);
    assign wb.wb_dat_i = fixed_en ? FIXED : mem_word(wb.wb_adr_o);
    always @(posedge clk or negedge reset) begin
        if (!reset)                                            slv_cnt <= 0;
        else if (wb.wb_cyc_o && wb.wb_stb_o && !wb.wb_ack_i)  slv_cnt <= slv_cnt + 1;
        else                                                   slv_cnt <= 0;
    end

    // Zero-wait slave for the wrap instance.
    assign wb2.wb_ack_i = wb2.wb_cyc_o && wb2.wb_stb_o;
    assign wb2.wb_dat_i = mem_word(wb2.wb_adr_o);

    task automatic apply_reset(input int w);
        reset         = 1'b0;
        sf            = 2'b00;
        branch_taken  = 1'b0;
        branch_target = '0;
        fixed_en      = 1'b0;
        wait_n        = w;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (wb.wb_ack_i) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; sf = 2'b00; branch_taken = 1'b0; branch_target = '0;
        wait_n = 0; fixed_en = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (wb.wb_cyc_o !== 1'b0) begin bad++; $display("FAIL reset_cyc: got=%b exp=0", wb.wb_cyc_o); end
        total++; if (wb.wb_stb_o !== 1'b0) begin bad++; $display("FAIL reset_stb: got=%b exp=0", wb.wb_stb_o); end
        total++; if (wb.wb_adr_o !== PC_A) begin bad++; $display("FAIL reset_adr: got=%h exp=%h", wb.wb_adr_o, PC_A); end
        total++; if (inst_o !== NOP) begin bad++; $display("FAIL reset_inst: got=%h exp=%h", inst_o, NOP); end
        total++; if (pc_o !== PC_A) begin bad++; $display("FAIL reset_pc: got=%h exp=%h", pc_o, PC_A); end
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b exp=0", inst_valid_o); end
        total++; if (im_busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b exp=0", im_busy_o); end
        total++; if (wb.wb_we_o !== 1'b0) begin bad++; $display("FAIL reset_we: got=%b exp=0", wb.wb_we_o); end
        total++; if (wb.wb_sel_o !== 4'hF) begin bad++; $display("FAIL reset_sel: got=%h exp=f", wb.wb_sel_o); end
`ifdef IF_BUS_TIMEOUT_EN
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got=%b exp=0", fault); end
`endif
        reset = 1'b1;
        @(negedge clk);
        total++; if (wb.wb_cyc_o !== 1'b1 || wb.wb_adr_o !== PC_A) begin
            bad++; $display("FAIL first_fetch: cyc=%b adr=%h exp cyc=1 adr=%h", wb.wb_cyc_o, wb.wb_adr_o, PC_A);
        end
        total++; if (im_busy_o !== 1'b1) begin bad++; $display("FAIL first_busy: got=%b exp=1", im_busy_o); end
    endtask

    task automatic test_zero_wait();
        apply_reset(0);
        fixed_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                total++; if (inst_valid_o !== 1'b1 || pc_o !== PC_A + 32'(4 * (k / 2 - 1)) || inst_o !== FIXED) begin
                    bad++; $display("FAIL zw_deliver k=%0d: valid=%b pc=%h inst=%h exp valid=1 pc=%h inst=%h",
                                    k, inst_valid_o, pc_o, inst_o, PC_A + 32'(4 * (k / 2 - 1)), FIXED);
                end
            end else begin
                total++; if (inst_valid_o !== 1'b0 || wb.wb_cyc_o !== 1'b1 || wb.wb_adr_o !== PC_A + 32'(4 * ((k - 1) / 2))) begin
                    bad++; $display("FAIL zw_fetch k=%0d: valid=%b cyc=%b adr=%h exp valid=0 cyc=1 adr=%h",
                                    k, inst_valid_o, wb.wb_cyc_o, wb.wb_adr_o, PC_A + 32'(4 * ((k - 1) / 2)));
                end
            end
        end
        fixed_en = 1'b0;
    endtask

    task automatic test_hold_stall();
        bit ok;
        apply_reset(3);
        wait_ack(ok);
        total++; if (!ok) begin bad++; $display("FAIL hold_ack_timeout: got=none exp=ack"); end
        sf[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++; if (inst_valid_o !== 1'b0 || wb.wb_cyc_o !== 1'b0 || im_busy_o !== 1'b0) begin
                bad++; $display("FAIL hold_quiet i=%0d: valid=%b cyc=%b busy=%b exp all 0", i, inst_valid_o, wb.wb_cyc_o, im_busy_o);
            end
            if (i == 4) sf[0] = 1'b0;
        end
        @(negedge clk);
        total++; if (inst_valid_o !== 1'b1 || pc_o !== PC_A || inst_o !== mem_word(PC_A)) begin
            bad++; $display("FAIL hold_deliver: valid=%b pc=%h inst=%h exp valid=1 pc=%h inst=%h",
                            inst_valid_o, pc_o, inst_o, PC_A, mem_word(PC_A));
        end
        total++; if (wb.wb_cyc_o !== 1'b1 || wb.wb_adr_o !== PC_A + 32'd4) begin
            bad++; $display("FAIL hold_next_fetch: cyc=%b adr=%h exp cyc=1 adr=%h", wb.wb_cyc_o, wb.wb_adr_o, PC_A + 32'd4);
        end
        @(negedge clk);
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL hold_single: got valid=%b exp=0", inst_valid_o); end
    endtask

    task automatic test_branch_drain();
        logic [31:0] acks[$];
        logic [31:0] vpc, vinst;
        bit          seen = 1'b0;
        apply_reset(3);
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'h8000_0100;
        @(negedge clk);
        branch_taken = 1'b0;
        total++; if (im_busy_o !== 1'b1 || wb.wb_cyc_o !== 1'b1 || wb.wb_adr_o !== PC_A) begin
            bad++; $display("FAIL drain_bus_kept: busy=%b cyc=%b adr=%h exp 1 1 %h", im_busy_o, wb.wb_cyc_o, wb.wb_adr_o, PC_A);
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            if (inst_valid_o) begin seen = 1'b1; vpc = pc_o; vinst = inst_o; end
            else if (wb.wb_ack_i) acks.push_back(wb.wb_adr_o);
            if (!seen) @(negedge clk);
        end
        total++; if (!seen || acks.size() != 2) begin
            bad++; $display("FAIL drain_sequence: delivered=%b acks=%0d exp delivered=1 acks=2", seen, acks.size());
        end else begin
            total++; if (acks[0] !== PC_A || acks[1] !== 32'h8000_0100) begin
                bad++; $display("FAIL drain_addrs: got=%h,%h exp=%h,%h", acks[0], acks[1], PC_A, 32'h8000_0100);
            end
            total++; if (vpc !== 32'h8000_0100 || vinst !== mem_word(32'h8000_0100)) begin
                bad++; $display("FAIL drain_deliver: pc=%h inst=%h exp pc=%h inst=%h", vpc, vinst, 32'h8000_0100, mem_word(32'h8000_0100));
            end
        end
    endtask

    // Common tail: run until first delivery, recording bus acks and early deliveries.
    task automatic watch_refetch(input string name, input logic [31:0] exp_adr);
        logic [31:0] first_ack = '0;
        int          n_ack = 0;
        int          early = 0;
        bit          seen = 1'b0;
        logic [31:0] vpc = '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (inst_valid_o) begin
                if (n_ack == 0) early++;
                else begin seen = 1'b1; vpc = pc_o; end
            end
            if (wb.wb_ack_i && n_ack == 0) begin first_ack = wb.wb_adr_o; n_ack = 1; end
        end
        total++; if (!seen || early != 0) begin
            bad++; $display("FAIL %s_no_stale: delivered=%b early=%0d exp delivered=1 early=0", name, seen, early);
        end
        total++; if (first_ack !== exp_adr) begin bad++; $display("FAIL %s_fetch_adr: got=%h exp=%h", name, first_ack, exp_adr); end
        total++; if (vpc !== exp_adr) begin bad++; $display("FAIL %s_deliver_pc: got=%h exp=%h", name, vpc, exp_adr); end
    endtask

    task automatic test_branch_in_hold();
        bit ok;
        apply_reset(1);
        wait_ack(ok);
        total++; if (!ok) begin bad++; $display("FAIL bh_ack_timeout: got=none exp=ack"); end
        sf[0] = 1'b1;
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'h8000_0200;
        @(negedge clk);
        branch_taken = 1'b0;
        sf = 2'b00;
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL bh_valid: got=%b exp=0", inst_valid_o); end
        watch_refetch("bh", 32'h8000_0200);
    endtask

    task automatic test_flush_in_hold();
        bit ok;
        apply_reset(0);
        wait_ack(ok);
        total++; if (!ok) begin bad++; $display("FAIL fh_ack_timeout: got=none exp=ack"); end
        sf[0] = 1'b1;
        @(negedge clk);
        sf = 2'b11;
        @(negedge clk);
        sf = 2'b00;
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL fh_valid: got=%b exp=0", inst_valid_o); end
        watch_refetch("fh", PC_A);
    endtask

    task automatic test_flush_delivery();
        bit ok;
        bit seen = 1'b0;
        apply_reset(0);
        wait_ack(ok);
        total++; if (!ok) begin bad++; $display("FAIL fd_ack_timeout: got=none exp=ack"); end
        @(negedge clk);
        total++; if (inst_valid_o !== 1'b1) begin bad++; $display("FAIL fd_pre_valid: got=%b exp=1", inst_valid_o); end
        sf[1] = 1'b1;
        #1;
        total++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin
            bad++; $display("FAIL fd_kill: valid=%b inst=%h exp valid=0 inst=%h", inst_valid_o, inst_o, NOP);
        end
        @(negedge clk);
        sf[1] = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (inst_valid_o) begin
                seen = 1'b1;
                total++; if (pc_o !== PC_A + 32'd4) begin bad++; $display("FAIL fd_next_pc: got=%h exp=%h", pc_o, PC_A + 32'd4); end
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL fd_next_timeout: got=none exp=delivery"); end
    endtask

    task automatic test_wrap();
        logic [31:0] acks[$];
        logic [31:0] pcs[$];
        apply_reset(0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wb2.wb_ack_i) acks.push_back(wb2.wb_adr_o);
            if (valid2) pcs.push_back(pc2);
        end
        total++; if (acks.size() < 3 || pcs.size() < 2) begin
            bad++; $display("FAIL wrap_count: acks=%0d pcs=%0d exp >=3 >=2", acks.size(), pcs.size());
        end else begin
            total++; if (acks[0] !== PC_W || acks[1] !== 32'h0 || acks[2] !== 32'h4) begin
                bad++; $display("FAIL wrap_addrs: got=%h,%h,%h exp=%h,0,4", acks[0], acks[1], acks[2], PC_W);
            end
            total++; if (pcs[0] !== PC_W || pcs[1] !== 32'h0) begin
                bad++; $display("FAIL wrap_pcs: got=%h,%h exp=%h,0", pcs[0], pcs[1], PC_W);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset(5);
        @(negedge clk);
        total++; if (wb.wb_cyc_o !== 1'b1) begin bad++; $display("FAIL ar_pre_cyc: got=%b exp=1", wb.wb_cyc_o); end
        #2 reset = 1'b0;
        #1;
        total++; if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || im_busy_o !== 1'b0 || wb.wb_adr_o !== PC_A) begin
            bad++; $display("FAIL ar_drop: cyc=%b stb=%b busy=%b adr=%h exp 0 0 0 %h",
                            wb.wb_cyc_o, wb.wb_stb_o, im_busy_o, wb.wb_adr_o, PC_A);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

`ifdef IF_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int busy_cycles = 0;
        bit seen = 1'b0;
        apply_reset(100000);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (fault) seen = 1'b1;
            else if (wb.wb_cyc_o) busy_cycles++;
        end
        total++; if (!seen || busy_cycles != 16) begin
            bad++; $display("FAIL to_latency: fault=%b busy_cycles=%0d exp fault=1 busy_cycles=16", seen, busy_cycles);
        end
        total++; if (inst_valid_o !== 1'b1 || inst_o !== NOP || pc_o !== PC_A || wb.wb_cyc_o !== 1'b0) begin
            bad++; $display("FAIL to_deliver: valid=%b inst=%h pc=%h cyc=%b exp 1 %h %h 0", inst_valid_o, inst_o, pc_o, wb.wb_cyc_o, NOP, PC_A);
        end
        @(negedge clk);
        total++; if (fault !== 1'b0 || wb.wb_cyc_o !== 1'b1 || wb.wb_adr_o !== PC_A + 32'd4) begin
            bad++; $display("FAIL to_next: fault=%b cyc=%b adr=%h exp 0 1 %h", fault, wb.wb_cyc_o, wb.wb_adr_o, PC_A + 32'd4);
        end
    endtask
`endif

    // Random wait states and stall pulses; the delivered stream must be the
    // sequential program order with each word fetched exactly once.
    task automatic test_random_stream();
        logic [31:0] exp_pc, exp_bus, prev_adr;
        bit          prev_pend = 1'b0;
        int          n = 0;
        int          stall_left = 0;
        apply_reset(0);
        exp_pc   = PC_A;
        exp_bus  = PC_A;
        prev_adr = '0;
        for (int c = 0; c < 3000 && n < 40; c++) begin
            @(negedge clk);
            if (inst_valid_o) begin
                total++; if (pc_o !== exp_pc || inst_o !== mem_word(exp_pc)) begin
                    bad++; $display("FAIL rnd_deliver n=%0d: pc=%h inst=%h exp pc=%h inst=%h", n, pc_o, inst_o, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4;
                n++;
            end
            total++; if (im_busy_o !== wb.wb_cyc_o) begin
                bad++; $display("FAIL rnd_busy: busy=%b exp=%b", im_busy_o, wb.wb_cyc_o);
            end
            if (prev_pend) begin
                total++; if (!(wb.wb_cyc_o && wb.wb_stb_o) || wb.wb_adr_o !== prev_adr) begin
                    bad++; $display("FAIL rnd_bus_stable: cyc=%b stb=%b adr=%h exp 1 1 %h", wb.wb_cyc_o, wb.wb_stb_o, wb.wb_adr_o, prev_adr);
                end
            end
            if (wb.wb_cyc_o && wb.wb_stb_o && wb.wb_ack_i) begin
                total++; if (wb.wb_adr_o !== exp_bus) begin
                    bad++; $display("FAIL rnd_bus_adr: got=%h exp=%h", wb.wb_adr_o, exp_bus);
                end
                exp_bus += 32'd4;
            end
            prev_pend = wb.wb_cyc_o && wb.wb_stb_o && !wb.wb_ack_i;
            prev_adr  = wb.wb_adr_o;
            if (!wb.wb_cyc_o) wait_n = int'($urandom_range(0, 3));
            if (stall_left > 0) stall_left--;
            else if ($urandom_range(0, 3) == 0) stall_left = int'($urandom_range(1, 4));
            sf[0] = (stall_left > 0);
        end
        sf = 2'b00;
        total++; if (n < 40) begin bad++; $display("FAIL rnd_progress: got=%0d deliveries exp=40", n); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_hold_stall();
        test_branch_drain();
        test_branch_in_hold();
        test_flush_delivery();
        test_flush_in_hold();
        test_wrap();
        test_async_reset();
`ifdef IF_BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
